mux3to1_rr_arb: RTL and testbench

Packet-level round-robin arbiter that shares one 3:1 data mux between three requesters (a, b, c) and one downstream consumer. It owns the mux select and holds a grant for a whole packet (until the beat flagged last is accepted), then rotates priority. It sits in front of the mux3to1 datapath and drives its `sel` encoding directly: 00=a, 01=b, 10=c, 11=none.

---
 rtl/mux3to1_rr_arb.sv | 110 +++++++++++
 tb/tb_mux3to1_rr_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux3to1_rr_arb.sv
// rtl/mux3to1_rr_arb.sv - packet-level round-robin arbiter driving a shared 3:1 data mux
module mux3to1_rr_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [2:0]       last,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic [WIDTH-1:0] c_data,
    output logic [2:0]       ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] g_q, g_d;
    logic [1:0] ptr_q, ptr_d;

    logic [1:0] cand1, cand2;
    logic       beat;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= 2'd0;
            ptr_q   <= 2'd2;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        ptr_d     = ptr_q;
        cand1     = 2'd0;
        cand2     = 2'd0;
        beat      = 1'b0;
        sel       = 2'b11;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        ready     = 3'b000;

        case (state_q)
            IDLE: begin
                cand1 = inc3(ptr_q);
                cand2 = inc3(cand1);
                if (req[cand1]) begin
                    g_d = cand1;
                end else if (req[cand2]) begin
                    g_d = cand2;
                end else if (req[ptr_q]) begin
                    g_d = ptr_q;
                end
                if (|req) begin
                    ptr_d   = g_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sel       = g_q;
                busy      = 1'b1;
                out_valid = req[g_q];
                out_last  = last[g_q] & req[g_q];
                case (g_q)
                    2'd0:    begin out_data = a_data; ready = {2'b00, out_ready};       end
                    2'd1:    begin out_data = b_data; ready = {1'b0, out_ready, 1'b0};  end
                    2'd2:    begin out_data = c_data; ready = {out_ready, 2'b00};       end
                    default: begin out_data = '0;     ready = 3'b000;                   end
                endcase
                beat = out_valid & out_ready;
                // Handover skips the finishing requester so it cannot be regranted back-to-back.
                if (beat && out_last) begin
                    cand1 = inc3(g_q);
                    cand2 = inc3(cand1);
                    if (req[cand1]) begin
                        g_d   = cand1;
                        ptr_d = cand1;
                    end else if (req[cand2]) begin
                        g_d   = cand2;
                        ptr_d = cand2;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux3to1_rr_arb.sv
// tb/tb_mux3to1_rr_arb.sv - directed self-checking bench for mux3to1_rr_arb
module tb_mux3to1_rr_arb;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] last;
    logic [7:0] a_data, b_data, c_data;
    logic [2:0] ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [1:0] sel;
    logic       busy;

    int checks;
    int failures;
    logic [7:0] dat [3];

    mux3to1_rr_arb #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .a_data   (a_data),
        .b_data   (b_data),
        .c_data   (c_data),
        .ready    (ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .sel      (sel),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req = 3'b000; last = 3'b000; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 3'b111; last = 3'b000; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({sel, busy, out_valid, out_last, ready} !== {2'b11, 1'b0, 1'b0, 1'b0, 3'b000}) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: got sel=%b busy=%b ov=%b ol=%b ready=%b, want sel=11 busy=0 ov=0 ol=0 ready=000",
                         i, sel, busy, out_valid, out_last, ready);
            end
            checks++;
            if (out_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_data cyc%0d: got %h want 00", i, out_data);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sel !== 2'b11) begin
            failures++;
            $display("FAIL reset_release_idle: got sel=%b want 11", sel);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({sel, busy, ready} !== {2'b00, 1'b1, 3'b001}) begin
            failures++;
            $display("FAIL reset_first_grant: got sel=%b busy=%b ready=%b want sel=00 busy=1 ready=001", sel, busy, ready);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] es;
        logic [2:0] er;
        apply_reset();
        req = 3'b111; last = 3'b111; out_ready = 1'b1;
        #1;
        checks++;
        if (sel !== 2'b11) begin
            failures++;
            $display("FAIL rot_idle: got sel=%b want 11", sel);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            es = 2'(k % 3);
            er = 3'b001 << es;
            checks++;
            if ({sel, ready, out_valid, out_last, out_data} !== {es, er, 1'b1, 1'b1, dat[k % 3]}) begin
                failures++;
                $display("FAIL rotation k%0d: got sel=%b ready=%b ov=%b ol=%b data=%h want sel=%b ready=%b ov=1 ol=1 data=%h",
                         k, sel, ready, out_valid, out_last, out_data, es, er, dat[k % 3]);
            end
        end
    endtask

    task automatic test_packet_hold();
        int beats;
        apply_reset();
        req = 3'b111; last = 3'b110; out_ready = 1'b0;
        #1;
        checks++;
        if (sel !== 2'b11) begin
            failures++;
            $display("FAIL hold_idle: got sel=%b want 11", sel);
        end
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            out_ready = (k % 2 == 0);
            last = (beats == 3) ? 3'b111 : 3'b110;
            #1;
            checks++;
            if ({sel, ready, out_last, out_data} !== {2'b00, 2'b00, out_ready, (beats == 3), 8'hA1}) begin
                failures++;
                $display("FAIL packet_hold k%0d: got sel=%b ready=%b ol=%b data=%h want sel=00 ready=00%b ol=%0d data=a1",
                         k, sel, ready, out_last, out_data, out_ready, (beats == 3));
            end
            if (out_ready) beats++;
        end
        @(negedge clk);
        out_ready = 1'b1; last = 3'b000;
        #1;
        checks++;
        if ({sel, ready} !== {2'b01, 3'b010}) begin
            failures++;
            $display("FAIL hold_handover: got sel=%b ready=%b want sel=01 ready=010", sel, ready);
        end
    endtask

    task automatic test_lone_requester();
        logic [1:0] seq [4];
        seq = '{2'b11, 2'b00, 2'b11, 2'b00};
        apply_reset();
        req = 3'b001; last = 3'b001; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if ({sel, busy} !== {seq[k], (seq[k] != 2'b11)}) begin
                failures++;
                $display("FAIL lone k%0d: got sel=%b busy=%b want sel=%b busy=%0d", k, sel, busy, seq[k], (seq[k] != 2'b11));
            end
        end
    endtask

    task automatic test_stall_gap();
        apply_reset();
        req = 3'b010; last = 3'b000; out_ready = 1'b1;
        #1;
        checks++;
        if (sel !== 2'b11) begin
            failures++;
            $display("FAIL stall_idle: got sel=%b want 11", sel);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({sel, out_valid, out_data} !== {2'b01, 1'b1, 8'hB2}) begin
            failures++;
            $display("FAIL stall_grant_b: got sel=%b ov=%b data=%h want sel=01 ov=1 data=b2", sel, out_valid, out_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 3'b101;
            #1;
            checks++;
            if ({sel, out_valid, busy, ready} !== {2'b01, 1'b0, 1'b1, 3'b010}) begin
                failures++;
                $display("FAIL stall_gap k%0d: got sel=%b ov=%b busy=%b ready=%b want sel=01 ov=0 busy=1 ready=010",
                         k, sel, out_valid, busy, ready);
            end
        end
        @(negedge clk);
        req = 3'b111; last = 3'b010;
        #1;
        checks++;
        if ({sel, out_valid, out_last} !== {2'b01, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL stall_last: got sel=%b ov=%b ol=%b want sel=01 ov=1 ol=1", sel, out_valid, out_last);
        end
        @(negedge clk);
        last = 3'b000;
        #1;
        checks++;
        if (sel !== 2'b10) begin
            failures++;
            $display("FAIL stall_handover: got sel=%b want 10", sel);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req = 3'b100; last = 3'b000; out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({sel, out_data} !== {2'b10, 8'hC3}) begin
            failures++;
            $display("FAIL midrst_grant_c: got sel=%b data=%h want sel=10 data=c3", sel, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 3'b101;
        #1;
        checks++;
        if ({sel, busy, ready, out_valid} !== {2'b11, 1'b0, 3'b000, 1'b0}) begin
            failures++;
            $display("FAIL midrst_idle: got sel=%b busy=%b ready=%b ov=%b want sel=11 busy=0 ready=000 ov=0",
                     sel, busy, ready, out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sel !== 2'b00) begin
            failures++;
            $display("FAIL midrst_regrant_a: got sel=%b want 00", sel);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req = 3'b000;
        last = 3'b000;
        out_ready = 1'b0;
        a_data = 8'hA1;
        b_data = 8'hB2;
        c_data = 8'hC3;
        dat[0] = 8'hA1;
        dat[1] = 8'hB2;
        dat[2] = 8'hC3;
        test_reset();
        test_rotation();
        test_packet_hold();
        test_lone_requester();
        test_stall_gap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
